// File: rtl/com_valid_lanes_pkg.sv
// rtl/com_valid_lanes_pkg.sv - shared PHY constants, width helper and lane packing macros
//
// Purpose : common definitions for the multi-lane transmit valid-conditioner.
// Contents: COMMA_K285 idle/alignment symbol, clog2w() counter-width helper,
//           CVL_LANE() macro selecting lane i of a packed multi-lane bus.

`ifndef COM_VALID_LANES_PKG_SV
`define COM_VALID_LANES_PKG_SV

// Lane i of a bus packed as {lane N-1, ..., lane 1, lane 0}, each w bits wide.
`define CVL_LANE(vec, i, w) vec[(i)*(w) +: (w)]

package com_valid_lanes_pkg;

   localparam logic [7:0] COMMA_K285 = 8'hBC;

   // Bits needed to count 0..n-1, never less than 1 so counters always exist.
   function automatic int clog2w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

`endif

// File: rtl/com_valid_lanes_if.sv
// rtl/com_valid_lanes_if.sv - multi-lane handshake bus for the transmit conditioner
//
// Purpose : groups the per-lane enable/valid/payload inputs and the
//           ready/symbol/K-flag outputs of com_valid_lanes.
// Signals : lane_en, valid, data_in (master -> slave)
//           ready_out, data_out, k_out (slave -> master)
//           data buses packed with lane i at [i*DATA_W +: DATA_W].

interface com_valid_lanes_if #(
   parameter int LANES  = 4,
   parameter int DATA_W = 8
);
   logic [LANES-1:0]        lane_en;
   logic [LANES-1:0]        valid;
   logic [LANES*DATA_W-1:0] data_in;
   logic [LANES-1:0]        ready_out;
   logic [LANES*DATA_W-1:0] data_out;
   logic [LANES-1:0]        k_out;

   modport master (
      output lane_en, valid, data_in,
      input  ready_out, data_out, k_out
   );

   modport slave (
      input  lane_en, valid, data_in,
      output ready_out, data_out, k_out
   );
endinterface

// File: rtl/com_valid_lanes_lane.sv
// rtl/com_valid_lanes_lane.sv - single-lane valid conditioner with idle gap and skip insertion
//
// Purpose : registers payload on accept, otherwise emits COMMA with k_out=1.
//           Holds off ready for MIN_GAP commas after a burst and forces one
//           skip comma after SYNC_PERIOD consecutive data words.
// Ports   : cclk      in   transmit clock
//           rst       in   asynchronous active-high reset
//           lane_en   in   lane enable; 0 zeroes outputs and clears counters
//           valid     in   payload valid
//           data_in   in   DATA_W payload
//           ready_out out  combinational accept, from lane state only
//           data_out  out  registered symbol
//           k_out     out  1 = data_out is the comma

module com_valid_lane
   import com_valid_lanes_pkg::*;
#(
   parameter int               DATA_W      = 8,
   parameter logic [DATA_W-1:0] COMMA      = DATA_W'(COMMA_K285),
   parameter int               MIN_GAP     = 3,
   parameter int               SYNC_PERIOD = 16
) (
   input  logic              cclk,
   input  logic              rst,
   input  logic              lane_en,
   input  logic              valid,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready_out,
   output logic [DATA_W-1:0] data_out,
   output logic              k_out
);

   localparam int               RUN_W    = clog2w(SYNC_PERIOD + 1);
   localparam int               GAP_W    = clog2w(MIN_GAP + 1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(SYNC_PERIOD);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP > 1 ? MIN_GAP - 1 : 0);
   localparam bit               SKIP_EN  = (SYNC_PERIOD != 0);

   logic [RUN_W-1:0] run_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             prev_data;
   logic             skip_due;
   logic             accept;

   assign skip_due  = SKIP_EN && (run_cnt == RUN_MAX);
   // Counters already read zero in reset; the explicit rst term keeps ready low then.
   assign ready_out = !rst && lane_en && (gap_cnt == '0) && !skip_due;
   assign accept    = valid && ready_out;

   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         data_out  <= '0;
         k_out     <= 1'b0;
         run_cnt   <= '0;
         gap_cnt   <= '0;
         prev_data <= 1'b0;
      end else if (!lane_en) begin
         data_out  <= '0;
         k_out     <= 1'b0;
         run_cnt   <= '0;
         gap_cnt   <= '0;
         prev_data <= 1'b0;
      end else if (accept) begin
         data_out  <= data_in;
         k_out     <= 1'b0;
         // With skips disabled the run length is irrelevant; pin it at zero.
         run_cnt   <= SKIP_EN ? run_cnt + 1'b1 : '0;
         prev_data <= 1'b1;
      end else begin
         data_out  <= COMMA;
         k_out     <= 1'b1;
         run_cnt   <= '0;
         prev_data <= 1'b0;
         // A comma that ends a burst loads the hold-off; a skip comma does not.
         if (prev_data && !skip_due)
            gap_cnt <= GAP_LOAD;
         else if (gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/com_valid_lanes.sv
// rtl/com_valid_lanes.sv - multi-lane transmit valid conditioner, top level
//
// Purpose : LANES independent com_valid_lane instances sharing one clock and
//           reset; unpacks and repacks the lane buses of com_valid_lanes_if.
// Ports   : cclk           in  transmit clock
//           default_values in  asynchronous active-high reset
//           bus            slave modport of com_valid_lanes_if

module com_valid_lanes
   import com_valid_lanes_pkg::*;
#(
   parameter int                LANES       = 4,
   parameter int                DATA_W      = 8,
   parameter logic [DATA_W-1:0] COMMA       = DATA_W'(COMMA_K285),
   parameter int                MIN_GAP     = 3,
   parameter int                SYNC_PERIOD = 16
) (
   input  logic          cclk,
   input  logic          default_values,
   com_valid_lanes_if.slave bus
);

   logic [LANES-1:0]        ready_w;
   logic [LANES*DATA_W-1:0] data_w;
   logic [LANES-1:0]        k_w;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      com_valid_lane #(
         .DATA_W      (DATA_W),
         .COMMA       (COMMA),
         .MIN_GAP     (MIN_GAP),
         .SYNC_PERIOD (SYNC_PERIOD)
      ) u_lane (
         .cclk      (cclk),
         .rst       (default_values),
         .lane_en   (bus.lane_en[i]),
         .valid     (bus.valid[i]),
         .data_in   (`CVL_LANE(bus.data_in, i, DATA_W)),
         .ready_out (ready_w[i]),
         .data_out  (`CVL_LANE(data_w, i, DATA_W)),
         .k_out     (k_w[i])
      );
   end

   assign bus.ready_out = ready_w;
   assign bus.data_out  = data_w;
   assign bus.k_out     = k_w;

endmodule

// File: tb/tb_com_valid_lanes.sv
// tb/tb_com_valid_lanes.sv - self-checking bench for com_valid_lanes

module tb_com_valid_lanes;

   logic cclk = 1'b0;
   logic default_values;

   always #5 cclk = ~cclk;

   com_valid_lanes_if #(.LANES(2), .DATA_W(8)) bus_a ();
   com_valid_lanes_if #(.LANES(2), .DATA_W(8)) bus_b ();

   com_valid_lanes #(
      .LANES(2), .DATA_W(8), .COMMA(8'hBC), .MIN_GAP(3), .SYNC_PERIOD(4)
   ) dut_a (
      .cclk(cclk), .default_values(default_values), .bus(bus_a)
   );

   com_valid_lanes #(
      .LANES(2), .DATA_W(8), .COMMA(8'hBC), .MIN_GAP(0), .SYNC_PERIOD(0)
   ) dut_b (
      .cclk(cclk), .default_values(default_values), .bus(bus_b)
   );

   typedef struct {
      int         dut;
      int         lane;
      logic [7:0] data;
      logic       k;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int dut, input int lane, input logic [7:0] d, input logic k);
      exp_t e;
      e.dut = dut; e.lane = lane; e.data = d; e.k = k;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge cclk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.dut == 0) begin
            check($sformatf("a.l%0d.data", e.lane), 32'(bus_a.data_out[e.lane*8 +: 8]), 32'(e.data));
            check($sformatf("a.l%0d.k", e.lane), 32'(bus_a.k_out[e.lane]), 32'(e.k));
         end else begin
            check($sformatf("b.l%0d.data", e.lane), 32'(bus_b.data_out[e.lane*8 +: 8]), 32'(e.data));
            check($sformatf("b.l%0d.k", e.lane), 32'(bus_b.k_out[e.lane]), 32'(e.k));
         end
      end
   endtask

   // Drive one cycle on one DUT, check ready before the edge, check outputs after it.
   task automatic step(input int dut, input logic [1:0] en, input logic [1:0] v,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] er,
                       input logic [7:0] x0, input logic k0, input logic [7:0] x1, input logic k1);
      if (dut == 0) begin
         bus_a.lane_en = en; bus_a.valid = v; bus_a.data_in = {d1, d0};
      end else begin
         bus_b.lane_en = en; bus_b.valid = v; bus_b.data_in = {d1, d0};
      end
      #1;
      if (dut == 0) check("a.ready", 32'(bus_a.ready_out), 32'(er));
      else          check("b.ready", 32'(bus_b.ready_out), 32'(er));
      push_exp(dut, 0, x0, k0);
      push_exp(dut, 1, x1, k1);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with random inputs
      default_values = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_a.lane_en = 2'($urandom); bus_a.valid = 2'($urandom); bus_a.data_in = 16'($urandom);
         bus_b.lane_en = 2'($urandom); bus_b.valid = 2'($urandom); bus_b.data_in = 16'($urandom);
         #2;
         check("rst.a.data",  32'(bus_a.data_out),  32'h0);
         check("rst.a.k",     32'(bus_a.k_out),     32'h0);
         check("rst.a.ready", 32'(bus_a.ready_out), 32'h0);
         check("rst.b.data",  32'(bus_b.data_out),  32'h0);
         check("rst.b.ready", 32'(bus_b.ready_out), 32'h0);
         @(posedge cclk);
         #1;
      end

      // Release with valid low: first edge emits commas
      bus_b.lane_en = 2'b00; bus_b.valid = 2'b00; bus_b.data_in = 16'h0;
      bus_a.lane_en = 2'b11; bus_a.valid = 2'b00; bus_a.data_in = 16'h0;
      default_values = 1'b0;
      step(0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b11, 8'hBC, 1, 8'hBC, 1);

      // Burst then gap on lane 0
      step(0, 2'b11, 2'b01, 8'h11, 8'h00, 2'b11, 8'h11, 0, 8'hBC, 1);
      step(0, 2'b11, 2'b01, 8'h22, 8'h00, 2'b11, 8'h22, 0, 8'hBC, 1);
      step(0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b11, 8'hBC, 1, 8'hBC, 1);
      step(0, 2'b11, 2'b01, 8'h33, 8'h00, 2'b10, 8'hBC, 1, 8'hBC, 1);
      step(0, 2'b11, 2'b01, 8'h33, 8'h00, 2'b10, 8'hBC, 1, 8'hBC, 1);
      step(0, 2'b11, 2'b01, 8'h33, 8'h00, 2'b11, 8'h33, 0, 8'hBC, 1);
      step(0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b11, 8'hBC, 1, 8'hBC, 1);

      // Skip insertion on lane 1 while lane 0 drains its gap
      step(0, 2'b11, 2'b10, 8'h00, 8'h01, 2'b10, 8'hBC, 1, 8'h01, 0);
      step(0, 2'b11, 2'b10, 8'h00, 8'h02, 2'b10, 8'hBC, 1, 8'h02, 0);
      step(0, 2'b11, 2'b10, 8'h00, 8'h03, 2'b11, 8'hBC, 1, 8'h03, 0);
      step(0, 2'b11, 2'b10, 8'h00, 8'h04, 2'b11, 8'hBC, 1, 8'h04, 0);
      step(0, 2'b11, 2'b10, 8'h00, 8'h05, 2'b01, 8'hBC, 1, 8'hBC, 1);
      step(0, 2'b11, 2'b10, 8'h00, 8'h05, 2'b11, 8'hBC, 1, 8'h05, 0);
      step(0, 2'b11, 2'b10, 8'h00, 8'h06, 2'b11, 8'hBC, 1, 8'h06, 0);
      step(0, 2'b11, 2'b10, 8'h00, 8'h07, 2'b11, 8'hBC, 1, 8'h07, 0);
      step(0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b11, 8'hBC, 1, 8'hBC, 1);
      step(0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b01, 8'hBC, 1, 8'hBC, 1);
      step(0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b01, 8'hBC, 1, 8'hBC, 1);

      // Lane independence: lane 0 short burst and gap, lane 1 streams A5
      for (int i = 0; i < 10; i++) begin
         step(0, 2'b11, {1'b1, i == 0}, 8'h44, 8'hA5,
              {(i % 5) != 4, !(i == 2 || i == 3)},
              (i == 0) ? 8'h44 : 8'hBC, i != 0,
              ((i % 5) == 4) ? 8'hBC : 8'hA5, (i % 5) == 4);
      end

      // Lane enable dropped mid-burst, then re-enabled without a gap
      step(0, 2'b11, 2'b01, 8'h55, 8'h00, 2'b11, 8'h55, 0, 8'hBC, 1);
      step(0, 2'b10, 2'b01, 8'h66, 8'h00, 2'b10, 8'h00, 0, 8'hBC, 1);
      step(0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b11, 8'hBC, 1, 8'hBC, 1);
      step(0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b11, 8'hBC, 1, 8'hBC, 1);

      // Asynchronous reset asserted mid-gap
      step(0, 2'b11, 2'b01, 8'h77, 8'h00, 2'b11, 8'h77, 0, 8'hBC, 1);
      step(0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b11, 8'hBC, 1, 8'hBC, 1);
      #2;
      default_values = 1'b1;
      #1;
      check("arst.a.data",  32'(bus_a.data_out),  32'h0);
      check("arst.a.k",     32'(bus_a.k_out),     32'h0);
      check("arst.a.ready", 32'(bus_a.ready_out), 32'h0);
      #1;
      default_values = 1'b0;
      bus_a.lane_en = 2'b11; bus_a.valid = 2'b01; bus_a.data_in = {8'h00, 8'h88};
      #1;
      check("arst.hold.data", 32'(bus_a.data_out), 32'h0);
      check("arst.gapclr.ready", 32'(bus_a.ready_out), 32'h3);
      push_exp(0, 0, 8'h88, 0);
      push_exp(0, 1, 8'hBC, 1);
      tick();

      // No hold-off, no skip: plain valid/comma mux
      bus_a.valid = 2'b00;
      step(1, 2'b01, 2'b01, 8'h10, 8'h00, 2'b01, 8'h10, 0, 8'h00, 0);
      step(1, 2'b01, 2'b01, 8'h20, 8'h00, 2'b01, 8'h20, 0, 8'h00, 0);
      step(1, 2'b01, 2'b01, 8'h30, 8'h00, 2'b01, 8'h30, 0, 8'h00, 0);
      step(1, 2'b01, 2'b01, 8'h40, 8'h00, 2'b01, 8'h40, 0, 8'h00, 0);
      step(1, 2'b01, 2'b01, 8'h50, 8'h00, 2'b01, 8'h50, 0, 8'h00, 0);
      step(1, 2'b01, 2'b01, 8'h60, 8'h00, 2'b01, 8'h60, 0, 8'h00, 0);
      step(1, 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 8'hBC, 1, 8'h00, 0);
      step(1, 2'b01, 2'b01, 8'h70, 8'h00, 2'b01, 8'h70, 0, 8'h00, 0);
      step(1, 2'b11, 2'b11, 8'h80, 8'h90, 2'b11, 8'h80, 0, 8'h90, 0);
      step(1, 2'b11, 2'b00, 8'h00, 8'h00, 2'b11, 8'hBC, 1, 8'hBC, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
